// File: rtl/irq_msi_arbiter_pkg.sv
// Shared types and constants for the MSI arbiter: FSM states, grant
// sources and the per-source MSI vector numbers.
package irq_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    HOLDOFF = 2'd2
  } irq_state_t;

  typedef enum logic {
    SRC_RX = 1'b0,
    SRC_TX = 1'b1
  } irq_src_t;

  localparam logic [7:0] MSI_VEC_RX = 8'd0;
  localparam logic [7:0] MSI_VEC_TX = 8'd1;

  // With a single granted vector both sources must share vector 0.
  function automatic logic [7:0] msi_vector(input irq_src_t src, input logic [2:0] mmenable);
    if (mmenable == 3'd0) return MSI_VEC_RX;
    return (src == SRC_TX) ? MSI_VEC_TX : MSI_VEC_RX;
  endfunction

endpackage

// File: rtl/irq_msi_arbiter_edge_pending.sv
// Rising-edge detector plus sticky pending flag for one interrupt source.
// A level held high yields one request; a new edge beats a same-cycle clear.
module irq_edge_pending (
  input  logic clk,
  input  logic rst,
  input  logic send_irq,
  input  logic clr,
  output logic pending
);

  logic prev;
  logic rise;

  assign rise = send_irq & ~prev;

  // Track the previous level and set/clear the pending flag (set wins).
  always_ff @(posedge clk) begin
    if (rst) begin
      prev    <= 1'b0;
      pending <= 1'b0;
    end else begin
      prev <= send_irq;
      if (rise)     pending <= 1'b1;
      else if (clr) pending <= 1'b0;
    end
  end

endmodule

// File: rtl/irq_msi_arbiter.sv
// Round-robin MSI arbiter between the tx and rx interrupt generators,
// driving the endpoint cfg_interrupt handshake with a post-accept holdoff.
//
// state   | meaning
// IDLE    | waiting for MSI enable and a pending source
// REQ     | cfg_interrupt_n low, waiting for cfg_interrupt_rdy_n low
// HOLDOFF | down-counting the gap before the next request may issue
module irq_msi_arbiter
  import irq_pkg::*;
#(
  parameter int HOLDOFF_CYCLES = 250,
  parameter int CNT_W          = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             send_irq_rx,
  input  logic             send_irq_tx,
  input  logic             cfg_interrupt_msienable,
  input  logic [2:0]       cfg_interrupt_mmenable,
  input  logic             cfg_interrupt_rdy_n,
  output logic             cfg_interrupt_n,
  output logic [7:0]       cfg_interrupt_di,
  output logic             cfg_interrupt_assert_n,
  output logic             irq_sent_rx,
  output logic             irq_sent_tx,
  output logic [CNT_W-1:0] irq_cnt_rx,
  output logic [CNT_W-1:0] irq_cnt_tx
);

  localparam logic [15:0] HOLD_LOAD = HOLDOFF_CYCLES[15:0];

  irq_state_t  state, state_nxt;
  irq_src_t    grant, last_grant, pick;
  logic [15:0] timer;
  logic        pend_rx, pend_tx;
  logic        issue, accept, clr_rx, clr_tx;

  assign cfg_interrupt_assert_n = 1'b1;

  irq_edge_pending u_pend_rx (
    .clk      (clk),
    .rst      (rst),
    .send_irq (send_irq_rx),
    .clr      (clr_rx),
    .pending  (pend_rx)
  );

  irq_edge_pending u_pend_tx (
    .clk      (clk),
    .rst      (rst),
    .send_irq (send_irq_tx),
    .clr      (clr_tx),
    .pending  (pend_tx)
  );

  // On a tie the source that did not win last time is granted.
  assign pick = (pend_rx && pend_tx) ? ((last_grant == SRC_TX) ? SRC_RX : SRC_TX)
                                     : (pend_tx ? SRC_TX : SRC_RX);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic; REQ ignores msienable so an issued MSI is never withdrawn.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (cfg_interrupt_msienable && (pend_rx || pend_tx)) state_nxt = REQ;
      REQ:     if (!cfg_interrupt_rdy_n) state_nxt = HOLDOFF;
      HOLDOFF: if (timer == 16'd0) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake strobes and pending-clear requests derived from the state.
  always_comb begin
    issue  = (state == IDLE) && cfg_interrupt_msienable && (pend_rx || pend_tx);
    accept = (state == REQ) && !cfg_interrupt_rdy_n;
    clr_rx = accept && (grant == SRC_RX);
    clr_tx = accept && (grant == SRC_TX);
  end

  // Registered handshake outputs, grant bookkeeping, holdoff timer and counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      cfg_interrupt_n  <= 1'b1;
      cfg_interrupt_di <= 8'd0;
      irq_sent_rx      <= 1'b0;
      irq_sent_tx      <= 1'b0;
      irq_cnt_rx       <= '0;
      irq_cnt_tx       <= '0;
      grant            <= SRC_TX;
      last_grant       <= SRC_TX;
      timer            <= 16'd0;
    end else begin
      irq_sent_rx <= 1'b0;
      irq_sent_tx <= 1'b0;
      if (issue) begin
        cfg_interrupt_n  <= 1'b0;
        cfg_interrupt_di <= msi_vector(pick, cfg_interrupt_mmenable);
        grant            <= pick;
      end
      if (accept) begin
        cfg_interrupt_n <= 1'b1;
        last_grant      <= grant;
        timer           <= HOLD_LOAD;
        if (grant == SRC_RX) begin
          irq_sent_rx <= 1'b1;
          irq_cnt_rx  <= irq_cnt_rx + CNT_W'(1);
        end else begin
          irq_sent_tx <= 1'b1;
          irq_cnt_tx  <= irq_cnt_tx + CNT_W'(1);
        end
      end else if (state == HOLDOFF && timer != 16'd0) begin
        timer <= timer - 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_irq_msi_arbiter.sv
// Self-checking bench for irq_msi_arbiter: directed scenarios with literal
// expectations plus a randomized run compared each cycle against a
// time-stamp based behavioural model.
module tb_irq_msi_arbiter;

  localparam int H  = 4;
  localparam int CW = 32;

  logic          clk = 1'b0;
  logic          rst, send_irq_rx, send_irq_tx, msien, rdy_n;
  logic [2:0]    mm;
  logic          cfg_interrupt_n, cfg_interrupt_assert_n, irq_sent_rx, irq_sent_tx;
  logic [7:0]    cfg_interrupt_di;
  logic [CW-1:0] irq_cnt_rx, irq_cnt_tx;

  always #5 clk = ~clk;

  irq_msi_arbiter #(.HOLDOFF_CYCLES(H), .CNT_W(CW)) dut (
    .clk                     (clk),
    .rst                     (rst),
    .send_irq_rx             (send_irq_rx),
    .send_irq_tx             (send_irq_tx),
    .cfg_interrupt_msienable (msien),
    .cfg_interrupt_mmenable  (mm),
    .cfg_interrupt_rdy_n     (rdy_n),
    .cfg_interrupt_n         (cfg_interrupt_n),
    .cfg_interrupt_di        (cfg_interrupt_di),
    .cfg_interrupt_assert_n  (cfg_interrupt_assert_n),
    .irq_sent_rx             (irq_sent_rx),
    .irq_sent_tx             (irq_sent_tx),
    .irq_cnt_rx              (irq_cnt_rx),
    .irq_cnt_tx              (irq_cnt_tx)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: index 0 = rx, 1 = tx. An MSI may issue once the
  // cycle count since the last accept reaches H+2 and a flag is pending.
  longint        cyc = 0;
  bit            model_on = 0;
  bit            m_n = 1;
  logic [7:0]    m_di = 8'd0;
  bit            m_srx = 0, m_stx = 0;
  logic [CW-1:0] m_crx = '0, m_ctx = '0;
  bit            p[2];
  bit            prv[2];
  int            last_g = 1;
  int            m_grant = 1;
  bit            have_acc = 0;
  longint        last_acc = 0;

  task automatic model_step();
    bit s[2];
    bit rise[2];
    int g;
    s[0] = send_irq_rx;
    s[1] = send_irq_tx;
    if (rst) begin
      m_n = 1; m_di = 8'd0; m_srx = 0; m_stx = 0; m_crx = '0; m_ctx = '0;
      p[0] = 0; p[1] = 0; prv[0] = 0; prv[1] = 0;
      last_g = 1; have_acc = 0; model_on = 1;
      return;
    end
    for (int i = 0; i < 2; i++) rise[i] = s[i] & ~prv[i];
    m_srx = 0;
    m_stx = 0;
    if (!m_n) begin
      if (!rdy_n) begin
        m_n = 1;
        if (m_grant == 0) begin m_srx = 1; m_crx = m_crx + 1; end
        else              begin m_stx = 1; m_ctx = m_ctx + 1; end
        last_g   = m_grant;
        have_acc = 1;
        last_acc = cyc;
        p[m_grant] = 0;
      end
    end else if (msien && (p[0] || p[1]) && (!have_acc || (cyc - last_acc) >= H + 2)) begin
      g = (p[0] && p[1]) ? (1 - last_g) : (p[1] ? 1 : 0);
      m_grant = g;
      m_n     = 0;
      m_di    = (mm == 3'd0) ? 8'd0 : ((g == 1) ? 8'd1 : 8'd0);
    end
    for (int i = 0; i < 2; i++) begin
      if (rise[i]) p[i] = 1;
      prv[i] = s[i];
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
    model_step();
  end

  // Per-cycle comparison against the model, away from the active edge.
  initial forever begin
    @(negedge clk);
    if (model_on) begin
      chk("m_cfg_n",   cfg_interrupt_n,        m_n);
      chk("m_di",      cfg_interrupt_di,       m_di);
      chk("m_sent_rx", irq_sent_rx,            m_srx);
      chk("m_sent_tx", irq_sent_tx,            m_stx);
      chk("m_cnt_rx",  irq_cnt_rx,             m_crx);
      chk("m_cnt_tx",  irq_cnt_tx,             m_ctx);
      chk("m_assert",  cfg_interrupt_assert_n, 1'b1);
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; send_irq_rx = 1'b0; send_irq_tx = 1'b0;
    cycle();
    rst = 1'b0;
  endtask

  task automatic count_lows(input int n, output int lows);
    lows = 0;
    for (int i = 0; i < n; i++) begin
      cycle();
      if (cfg_interrupt_n === 1'b0) lows++;
    end
  endtask

  int lows;

  initial begin
    rst = 1'b1; send_irq_rx = 1'b0; send_irq_tx = 1'b0;
    msien = 1'b0; mm = 3'd0; rdy_n = 1'b1;
    cycle(); cycle();
    rst = 1'b0;
    chk("rst_cfg_n",  cfg_interrupt_n,  1'b1);
    chk("rst_di",     cfg_interrupt_di, 8'd0);
    chk("rst_sent",   {irq_sent_rx, irq_sent_tx}, 2'b00);
    chk("rst_cnt_rx", irq_cnt_rx, 0);
    chk("rst_cnt_tx", irq_cnt_tx, 0);

    // Single tx request held high.
    msien = 1'b1; mm = 3'd1; rdy_n = 1'b1;
    send_irq_tx = 1'b1;
    cycle();
    chk("t1_not_yet", cfg_interrupt_n, 1'b1);
    cycle();
    chk("t1_req_n", cfg_interrupt_n, 1'b0);
    chk("t1_di", cfg_interrupt_di, 8'd1);
    cycle(); cycle();
    rdy_n = 1'b0;
    cycle();
    chk("t1_sent_tx", irq_sent_tx, 1'b1);
    chk("t1_cnt_tx", irq_cnt_tx, 1);
    chk("t1_released", cfg_interrupt_n, 1'b1);
    rdy_n = 1'b1;
    count_lows(20, lows);
    chk("t1_no_second", lows, 0);

    // Simultaneous rise, rdy_n tied low: rx first, then tx after holdoff.
    do_reset();
    msien = 1'b1; mm = 3'd1; rdy_n = 1'b0;
    send_irq_rx = 1'b1; send_irq_tx = 1'b1;
    cycle();
    cycle();
    chk("t2_first_n", cfg_interrupt_n, 1'b0);
    chk("t2_first_di", cfg_interrupt_di, 8'd0);
    cycle();
    chk("t2_sent_rx", irq_sent_rx, 1'b1);
    count_lows(5, lows);
    chk("t2_gap", lows, 0);
    cycle();
    chk("t2_second_n", cfg_interrupt_n, 1'b0);
    chk("t2_second_di", cfg_interrupt_di, 8'd1);
    cycle();
    chk("t2_sent_tx", irq_sent_tx, 1'b1);
    chk("t2_cnt_rx", irq_cnt_rx, 1);
    chk("t2_cnt_tx", irq_cnt_tx, 1);

    // MSI disabled: request waits, then issues on enable.
    do_reset();
    msien = 1'b0; mm = 3'd1; rdy_n = 1'b0;
    send_irq_rx = 1'b1;
    cycle();
    send_irq_rx = 1'b0;
    count_lows(20, lows);
    chk("t3_held_off", lows, 0);
    msien = 1'b1;
    cycle();
    chk("t3_req_n", cfg_interrupt_n, 1'b0);
    chk("t3_di", cfg_interrupt_di, 8'd0);
    cycle();
    chk("t3_sent_rx", irq_sent_rx, 1'b1);
    rdy_n = 1'b1;

    // Re-rise of tx on the accept edge keeps it pending.
    do_reset();
    msien = 1'b1; mm = 3'd1; rdy_n = 1'b1;
    send_irq_tx = 1'b1;
    cycle(); cycle();
    chk("t4_req", cfg_interrupt_n, 1'b0);
    repeat (6) cycle();
    send_irq_tx = 1'b0;
    cycle();
    send_irq_tx = 1'b1; rdy_n = 1'b0;
    cycle();
    chk("t4_sent_tx", irq_sent_tx, 1'b1);
    chk("t4_cnt_1", irq_cnt_tx, 1);
    count_lows(5, lows);
    chk("t4_gap", lows, 0);
    cycle();
    chk("t4_second_req", cfg_interrupt_n, 1'b0);
    chk("t4_second_di", cfg_interrupt_di, 8'd1);
    cycle();
    chk("t4_cnt_2", irq_cnt_tx, 2);

    // Single vector: both sources use vector 0.
    do_reset();
    msien = 1'b1; mm = 3'd0; rdy_n = 1'b0;
    send_irq_rx = 1'b1; send_irq_tx = 1'b1;
    cycle(); cycle();
    chk("t5_first_n", cfg_interrupt_n, 1'b0);
    chk("t5_first_di", cfg_interrupt_di, 8'd0);
    cycle();
    repeat (5) cycle();
    cycle();
    chk("t5_second_n", cfg_interrupt_n, 1'b0);
    chk("t5_second_di", cfg_interrupt_di, 8'd0);
    cycle();
    chk("t5_cnt_rx", irq_cnt_rx, 1);
    chk("t5_cnt_tx", irq_cnt_tx, 1);

    // Reset while a request is outstanding.
    send_irq_rx = 1'b0; send_irq_tx = 1'b0; mm = 3'd1; rdy_n = 1'b1;
    repeat (6) cycle();
    send_irq_tx = 1'b1;
    cycle(); cycle();
    chk("t6_req", cfg_interrupt_n, 1'b0);
    rst = 1'b1; send_irq_tx = 1'b0;
    cycle();
    rst = 1'b0;
    chk("t6_n_after_rst", cfg_interrupt_n, 1'b1);
    chk("t6_cnt_rx", irq_cnt_rx, 0);
    chk("t6_cnt_tx", irq_cnt_tx, 0);
    count_lows(20, lows);
    chk("t6_quiet", lows, 0);
    send_irq_tx = 1'b1;
    cycle(); cycle();
    chk("t6_new_req", cfg_interrupt_n, 1'b0);
    rdy_n = 1'b0;
    cycle();

    // Randomized traffic checked by the model every cycle.
    do_reset();
    msien = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(7) == 0) send_irq_rx = ~send_irq_rx;
      if ($urandom_range(7) == 0) send_irq_tx = ~send_irq_tx;
      if ($urandom_range(49) == 0) msien = ($urandom_range(3) != 0);
      if ($urandom_range(99) == 0) mm = 3'($urandom_range(7));
      rdy_n = ($urandom_range(2) != 0);
      rst   = ($urandom_range(699) == 0);
      cycle();
    end
    rst = 1'b0;
    cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
